huff_decoder: RTL and testbench

HUFF_DECODER -- requirements
Module: huff_decoder

---
 rtl/huff_decoder.sv | 195 +++++++++++++++++++
 tb/tb_huff_decoder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/huff_decoder.sv
// Three-entry prefix-code decoder: a load phase fills the code table, then
// BIT commands are shifted MSB-first into an accumulator and matched each cycle.

module huff_match_lane (
  input  logic       vld_i,
  input  logic [2:0] mask_i,
  input  logic [2:0] value_i,
  input  logic [2:0] acc_i,
  input  logic [1:0] len_i,
  output logic       hit_o
);
  logic [1:0] code_len;

  // Only masks contiguous from bit 0 give a usable length; all others never match.
  always_comb begin
    code_len = 2'd0;
    case (mask_i)
      3'b001:  code_len = 2'd1;
      3'b011:  code_len = 2'd2;
      3'b111:  code_len = 2'd3;
      default: code_len = 2'd0;
    endcase
  end

  assign hit_o = vld_i && (code_len != 2'd0) && (len_i == code_len) &&
                 ((acc_i & mask_i) == value_i);
endmodule

module huff_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);
  localparam int NUM_ENTRIES = 3;

  localparam logic [1:0] CMD_LOAD_SYM  = 2'b00;
  localparam logic [1:0] CMD_LOAD_CODE = 2'b01;
  localparam logic [1:0] CMD_BIT       = 2'b10;
  localparam logic [1:0] CMD_CTRL      = 2'b11;

  typedef enum logic [1:0] {ST_LOAD_SYM, ST_LOAD_CODE, ST_DECODE} state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] cmd;
    logic [8:0] payload;
  } req_t;

  req_t req;
  logic unused_payload;
  assign req            = io_in;
  assign unused_payload = req.payload[8];

  state_t                             state_q, state_d;
  logic [NUM_ENTRIES-1:0][7:0]        sym_q, sym_d;
  logic [NUM_ENTRIES-1:0][2:0]        mask_q, mask_d;
  logic [NUM_ENTRIES-1:0][2:0]        val_q, val_d;
  logic [NUM_ENTRIES-1:0]             vld_q, vld_d;
  logic [1:0]                         cnt_q, cnt_d;
  logic [2:0]                         acc_q, acc_d;
  logic [1:0]                         len_q, len_d;
  logic [7:0]                         symbol_q, symbol_d;
  logic                               sym_valid_q, sym_valid_d;
  logic                               error_q, error_d;
  logic                               partial_q, partial_d;
  logic                               table_ready_q, table_ready_d;

  logic [2:0]             new_acc;
  logic [1:0]             new_len;
  logic [NUM_ENTRIES-1:0] hit;
  logic [7:0]             hit_sym;
  logic                   any_hit;

  assign new_acc = {acc_q[1:0], req.payload[0]};
  assign new_len = len_q + 2'd1;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_lane
    huff_match_lane u_lane (
      .vld_i   (vld_q[i]),
      .mask_i  (mask_q[i]),
      .value_i (val_q[i]),
      .acc_i   (new_acc),
      .len_i   (new_len),
      .hit_o   (hit[i])
    );
  end

  // Scan high-to-low so the lowest matching slot is the one left standing.
  always_comb begin
    hit_sym = sym_q[0];
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (hit[i]) hit_sym = sym_q[i];
    end
  end
  assign any_hit = |hit;

  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    mask_d      = mask_q;
    val_d       = val_q;
    vld_d       = vld_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    len_d       = len_q;
    symbol_d    = symbol_q;
    sym_valid_d = 1'b0;
    error_d     = 1'b0;

    if (req.valid) begin
      case (req.cmd)
        CMD_LOAD_SYM: begin
          if (state_q == ST_LOAD_SYM && cnt_q != 2'd3) begin
            sym_d[cnt_q] = req.payload[7:0];
            state_d      = ST_LOAD_CODE;
          end
        end
        CMD_LOAD_CODE: begin
          if (state_q == ST_LOAD_CODE && cnt_q != 2'd3) begin
            mask_d[cnt_q] = req.payload[5:3];
            val_d[cnt_q]  = req.payload[2:0];
            vld_d[cnt_q]  = 1'b1;
            cnt_d         = cnt_q + 2'd1;
            state_d       = (cnt_q == 2'd2) ? ST_DECODE : ST_LOAD_SYM;
          end
        end
        CMD_BIT: begin
          if (state_q != ST_DECODE) begin
            error_d = 1'b1;
          end else if (any_hit) begin
            symbol_d    = hit_sym;
            sym_valid_d = 1'b1;
            acc_d       = 3'd0;
            len_d       = 2'd0;
          end else if (new_len == 2'd3) begin
            error_d = 1'b1;
            acc_d   = 3'd0;
            len_d   = 2'd0;
          end else begin
            acc_d = new_acc;
            len_d = new_len;
          end
        end
        CMD_CTRL: begin
          acc_d = 3'd0;
          len_d = 2'd0;
          if (req.payload[0]) begin
            vld_d   = '0;
            cnt_d   = 2'd0;
            state_d = ST_LOAD_SYM;
          end
        end
        default: ;
      endcase
    end

    partial_d     = (len_d != 2'd0);
    table_ready_d = (state_d == ST_DECODE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOAD_SYM;
      sym_q         <= '0;
      mask_q        <= '0;
      val_q         <= '0;
      vld_q         <= '0;
      cnt_q         <= 2'd0;
      acc_q         <= 3'd0;
      len_q         <= 2'd0;
      symbol_q      <= 8'd0;
      sym_valid_q   <= 1'b0;
      error_q       <= 1'b0;
      partial_q     <= 1'b0;
      table_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sym_q         <= sym_d;
      mask_q        <= mask_d;
      val_q         <= val_d;
      vld_q         <= vld_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      len_q         <= len_d;
      symbol_q      <= symbol_d;
      sym_valid_q   <= sym_valid_d;
      error_q       <= error_d;
      partial_q     <= partial_d;
      table_ready_q <= table_ready_d;
    end
  end

  assign io_out = {table_ready_q, partial_q, error_q, sym_valid_q, symbol_q};
endmodule

// File: tb/tb_huff_decoder.sv
// Directed vector bench for huff_decoder: table load, decode, error, flush/clear, reset.

module tb_huff_decoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] io_in = 12'h000;
  logic [11:0] io_out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] LS = 2'b00;
  localparam logic [1:0] LC = 2'b01;
  localparam logic [1:0] BT = 2'b10;
  localparam logic [1:0] CT = 2'b11;

  huff_decoder dut (
    .clk    (clk),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [11:0] din;
    logic [11:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] c(input logic [1:0] op, input logic [8:0] p);
    return {1'b1, op, p};
  endfunction

  task automatic add(input logic r, input logic [11:0] d, input logic [11:0] e, input string t);
    vec_t v;
    v.rst = r; v.din = d; v.exp = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [11:0] d, input logic [11:0] e, input string t);
    @(negedge clk);
    reset = r;
    io_in = d;
    @(posedge clk);
    #1;
    n_cmp++;
    if (io_out !== e) begin
      n_bad++;
      $display("FAIL %s: io_out=%h expected %h", t, io_out, e);
    end
  endtask

  initial begin
    // reset, pre-table BIT, ignored commands
    add(1, 12'h000,            12'h000, "reset_state");
    add(0, c(BT, 9'h001),      12'h200, "bit_before_table");
    add(0, {1'b0, BT, 9'h001}, 12'h000, "invalid_ignored");
    add(0, c(LC, 9'h008),      12'h000, "lc_in_load_sym_ignored");
    // table 1: A 41 (001,000) B 42 (011,010) C 43 (011,011)
    add(0, c(LS, 9'h041),      12'h000, "t1_ls_a");
    add(0, c(LC, 9'h008),      12'h000, "t1_lc_a");
    add(0, c(LS, 9'h042),      12'h000, "t1_ls_b");
    add(0, c(LC, 9'h01A),      12'h000, "t1_lc_b");
    add(0, c(LS, 9'h043),      12'h000, "t1_ls_c");
    add(0, c(LC, 9'h01B),      12'h800, "t1_table_ready");
    add(0, c(BT, 9'h000),      12'h941, "dec_a");
    add(0, c(BT, 9'h001),      12'hC41, "dec_partial1");
    add(0, c(BT, 9'h000),      12'h942, "dec_b");
    add(0, c(BT, 9'h001),      12'hC42, "dec_partial2");
    add(0, c(BT, 9'h001),      12'h943, "dec_c");
    add(0, 12'h000,            12'h843, "sym_valid_one_cycle");
    add(0, c(LS, 9'h099),      12'h843, "ls_in_decode_ignored");
    add(0, c(BT, 9'h001),      12'hC43, "flush_partial_set");
    add(0, c(CT, 9'h000),      12'h843, "flush_clears_partial");
    add(0, 12'h000,            12'h843, "flush_idle");
    add(0, c(CT, 9'h001),      12'h043, "clear_table");
    add(0, c(BT, 9'h001),      12'h243, "bit_after_clear");
    add(0, 12'h000,            12'h043, "error_one_cycle");
    // table 2: C becomes (111,111); bits 1,1,0 exhaust length 3
    add(0, c(LS, 9'h041),      12'h043, "t2_ls_a");
    add(0, c(LC, 9'h008),      12'h043, "t2_lc_a");
    add(0, c(LS, 9'h042),      12'h043, "t2_ls_b");
    add(0, c(LC, 9'h01A),      12'h043, "t2_lc_b");
    add(0, c(LS, 9'h043),      12'h043, "t2_ls_c");
    add(0, c(LC, 9'h03F),      12'h843, "t2_table_ready");
    add(0, c(BT, 9'h001),      12'hC43, "t2_bit1");
    add(0, c(BT, 9'h001),      12'hC43, "t2_bit2");
    add(0, c(BT, 9'h000),      12'hA43, "t2_len3_error");
    add(0, 12'h000,            12'h843, "t2_idle");
    // table 3: duplicate codes in slots 0/1, slot 2 mask 010 unmatchable
    add(0, c(CT, 9'h001),      12'h043, "t3_clear");
    add(0, c(LS, 9'h051),      12'h043, "t3_ls_a");
    add(0, c(LC, 9'h009),      12'h043, "t3_lc_a");
    add(0, c(LS, 9'h052),      12'h043, "t3_ls_b");
    add(0, c(LC, 9'h009),      12'h043, "t3_lc_b");
    add(0, c(LS, 9'h053),      12'h043, "t3_ls_c");
    add(0, c(LC, 9'h010),      12'h843, "t3_table_ready");
    add(0, c(BT, 9'h001),      12'h951, "t3_lowest_slot_wins");
    add(0, c(BT, 9'h000),      12'hC51, "t3_bit0_a");
    add(0, c(BT, 9'h000),      12'hC51, "t3_bit0_b");
    add(0, c(BT, 9'h000),      12'hA51, "t3_noncontig_error");
    add(0, 12'h000,            12'h851, "t3_idle");
    // reset after two entries, then full reload
    add(0, c(CT, 9'h001),      12'h051, "r_clear");
    add(0, c(LS, 9'h061),      12'h051, "r_ls_a");
    add(0, c(LC, 9'h008),      12'h051, "r_lc_a");
    add(0, c(LS, 9'h062),      12'h051, "r_ls_b");
    add(0, c(LC, 9'h01A),      12'h051, "r_lc_b");
    add(1, 12'h000,            12'h000, "r_reset_two_loaded");
    add(0, c(LS, 9'h041),      12'h000, "r2_ls_a");
    add(0, c(LC, 9'h008),      12'h000, "r2_lc_a");
    add(0, c(LS, 9'h042),      12'h000, "r2_ls_b");
    add(0, c(LC, 9'h01A),      12'h000, "r2_lc_b");
    add(0, c(LS, 9'h043),      12'h000, "r2_ls_c");
    add(0, c(LC, 9'h01B),      12'h800, "r2_table_ready");
    add(0, c(BT, 9'h001),      12'hC00, "r2_bit1");
    add(0, c(BT, 9'h001),      12'h943, "r2_dec_c");
    add(0, c(BT, 9'h000),      12'h941, "r2_dec_a");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].din, vecs[i].exp, vecs[i].tag);
    end

    // Reset on the same edge as a LOAD_CODE mid-load: the code is dropped and
    // the slot must be reloaded from LOAD_SYM.
    step(0, c(CT, 9'h001), 12'h041, "m_clear");
    step(0, c(LS, 9'h077), 12'h041, "m_ls");
    step(1, c(LC, 9'h008), 12'h000, "m_reset_with_lc");
    step(0, c(LC, 9'h008), 12'h000, "m_lc_after_reset_ignored");
    step(0, c(LS, 9'h078), 12'h000, "m_ls2");
    step(0, c(LC, 9'h008), 12'h000, "m_lc2");
    step(0, c(BT, 9'h000), 12'h200, "m_bit_partial_table");
    step(0, 12'h000,       12'h000, "m_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
